// File: rtl/alu_sequencer.sv
// Instruction sequencer for the registered 8-bit add/sub ALU: fetches from a
// combinational ROM, owns the A/B operand registers and writes ALU results back into A.
module alu_sequencer #(
    parameter int PROG_AW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [PROG_AW-1:0] pc_out,
    input  logic [7:0]         instr,
    output logic [7:0]         alu_a,
    output logic [7:0]         alu_b,
    output logic               alu_sel,
    input  logic [7:0]         alu_res,
    output logic [7:0]         out_data,
    output logic               out_valid,
    output logic               busy,
    output logic               halted
);

    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_t;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_LDB = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_OUT = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t             state, state_nxt;
    logic [PROG_AW-1:0] pc, pc_nxt;
    logic [7:0]         ir, ir_nxt;
    logic [7:0]         a, a_nxt;
    logic [7:0]         b, b_nxt;
    logic [7:0]         out_nxt;
    logic               ov_nxt;
    logic [3:0]         op;
    logic [3:0]         imm;

    // Zero-extends or truncates the 4-bit immediate to a program address.
    function automatic logic [PROG_AW-1:0] imm_to_pc(input logic [3:0] val);
        logic [PROG_AW-1:0] r;
        r = '0;
        for (int i = 0; i < PROG_AW && i < 4; i++) r[i] = val[i];
        return r;
    endfunction

    assign op        = ir[7:4];
    assign imm       = ir[3:0];
    assign pc_out    = pc;
    assign alu_a     = a;
    assign alu_b     = b;
    assign alu_sel   = (op == OP_SUB);
    assign busy      = (state == FETCH) || (state == DECODE) || (state == EXEC) || (state == WB);
    assign halted    = (state == HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= '0;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            ir        <= ir_nxt;
            a         <= a_nxt;
            b         <= b_nxt;
            out_data  <= out_nxt;
            out_valid <= ov_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        a_nxt     = a;
        b_nxt     = b;
        out_nxt   = out_data;
        ov_nxt    = 1'b0;
        case (state)
            IDLE:   if (start) state_nxt = FETCH;
            FETCH: begin
                ir_nxt    = instr;
                state_nxt = DECODE;
            end
            DECODE: begin
                pc_nxt    = pc + PROG_AW'(1);
                state_nxt = FETCH;
                case (op)
                    OP_LDA: a_nxt = {4'h0, imm};
                    OP_LDB: b_nxt = {4'h0, imm};
                    OP_ADD, OP_SUB: state_nxt = EXEC;
                    OP_OUT: begin
                        out_nxt = a;
                        ov_nxt  = 1'b1;
                    end
                    OP_JMP: pc_nxt = imm_to_pc(imm);
                    OP_JZ:  if (a == 8'h00) pc_nxt = imm_to_pc(imm);
                    OP_HLT: begin
                        pc_nxt    = pc;
                        state_nxt = HALT;
                    end
                    default: ;
                endcase
            end
            // Operands are held this cycle; the ALU registers its result at the edge.
            EXEC:   state_nxt = WB;
            WB: begin
                a_nxt     = alu_res;
                state_nxt = FETCH;
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ROM and registered ALU.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] pc_out;
    logic [7:0] instr;
    logic [7:0] alu_a, alu_b, alu_res;
    logic       alu_sel;
    logic [7:0] out_data;
    logic       out_valid, busy, halted;

    logic [7:0] rom [16];
    int checks = 0;
    int errors = 0;

    logic       mon_clr = 1'b1;
    logic       chk_add = 1'b0;
    int         ov_cnt, wb_cnt, sub_cnt, model_bad;
    logic [7:0] prev_a;

    alu_sequencer #(.PROG_AW(4)) dut (
        .clk(clk), .rst(rst), .start(start), .pc_out(pc_out), .instr(instr),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_res(alu_res),
        .out_data(out_data), .out_valid(out_valid), .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    assign instr = rom[pc_out];

    always @(posedge clk) alu_res <= alu_sel ? alu_a - alu_b : alu_a + alu_b;

    // Observes out_valid pulses and every change of A against a wrap-around adder model.
    always @(negedge clk) begin
        if (mon_clr) begin
            ov_cnt = 0; wb_cnt = 0; sub_cnt = 0; model_bad = 0;
        end else begin
            if (out_valid === 1'b1) ov_cnt++;
            if (alu_a !== prev_a) begin
                wb_cnt++;
                if (alu_sel === 1'b1) sub_cnt++;
                if (chk_add && alu_a !== 8'(prev_a + alu_b)) model_bad++;
            end
        end
        prev_a = alu_a;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        mon_clr = 1'b1;
        #2;
        rst = 1'b0;
        tick();
        mon_clr = 1'b0;
    endtask

    // Starts at the negedge after FETCH entry.
    task automatic launch(input logic hold);
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
    endtask

    task automatic run_to_halt(output int cyc);
        cyc = 0;
        while (halted !== 1'b1 && cyc < 300) begin
            tick();
            cyc++;
        end
    endtask

    int cyc;

    initial begin
        #1;
        check("reset_busy", busy, 0);
        check("reset_halted", halted, 0);
        check("reset_pc", pc_out, 0);
        check("reset_alu_a", alu_a, 0);
        check("reset_alu_b", alu_b, 0);
        check("reset_alu_sel", alu_sel, 0);
        check("reset_out", {out_valid, out_data}, 0);

        // LDA 5, LDB 3, ADD, OUT, HLT
        rom = '{0: 8'h15, 1: 8'h23, 2: 8'h30, 3: 8'h50, 4: 8'hF0, default: 8'h00};
        do_reset();
        launch(1'b0);
        check("add_busy_fetch", busy, 1);
        run_to_halt(cyc);
        check("add_cycles", cyc, 12);
        check("add_out_data", out_data, 8'h08);
        check("add_ov_pulses", ov_cnt, 1);
        check("add_pc", pc_out, 4);
        check("add_halted", {halted, busy}, 2'b10);

        // LDA 2, LDB 3, SUB, OUT, HLT: 2 - 3 wraps to 0xFF
        rom = '{0: 8'h12, 1: 8'h23, 2: 8'h40, 3: 8'h50, 4: 8'hF0, default: 8'h00};
        do_reset();
        launch(1'b0);
        run_to_halt(cyc);
        check("sub_cycles", cyc, 12);
        check("sub_out_data", out_data, 8'hFF);
        check("sub_ov_pulses", ov_cnt, 1);

        // LDB 0xF then ADD forever; 20 adds of 0xF from 0 give 300 mod 256
        rom = '{0: 8'h2F, default: 8'h30};
        do_reset();
        chk_add = 1'b1;
        launch(1'b0);
        cyc = 0;
        while (wb_cnt < 20 && cyc < 500) begin
            tick();
            cyc++;
        end
        chk_add = 1'b0;
        check("chain_wb_count", wb_cnt, 20);
        check("chain_model", model_bad, 0);
        check("chain_final_a", alu_a, 8'h2C);
        check("chain_b", alu_b, 8'h0F);

        // Countdown from 3 via SUB/JZ/JMP loop
        rom = '{0: 8'h13, 1: 8'h21, 2: 8'h40, 3: 8'h76, 4: 8'h62,
                5: 8'h00, 6: 8'h50, 7: 8'hF0, default: 8'h00};
        do_reset();
        launch(1'b0);
        run_to_halt(cyc);
        check("loop_cycles", cyc, 30);
        check("loop_sub_count", sub_cnt, 3);
        check("loop_out_data", out_data, 8'h00);
        check("loop_ov_pulses", ov_cnt, 1);
        check("loop_pc", pc_out, 7);

        // All NOPs: pc walks 0..15 and wraps, 2 cycles per step
        rom = '{default: 8'h00};
        do_reset();
        launch(1'b0);
        for (int s = 0; s < 18; s++) begin
            check($sformatf("wrap_pc_%0d", s), pc_out, s % 16);
            check($sformatf("wrap_busy_%0d", s), busy, 1);
            tick();
            tick();
        end

        // Asynchronous reset in the EXEC cycle of an ADD
        rom = '{0: 8'h15, 1: 8'h23, 2: 8'h30, 3: 8'h50, 4: 8'hF0, default: 8'h00};
        do_reset();
        launch(1'b0);
        repeat (6) tick();
        check("exec_operands", {alu_a, alu_b, alu_sel}, {8'h05, 8'h03, 1'b0});
        rst = 1'b1;
        #1;
        check("async_ops", {alu_a, alu_b, alu_sel}, 0);
        check("async_ctrl", {busy, halted, pc_out}, 0);
        check("async_out", {out_valid, out_data}, 0);
        rst = 1'b0;
        repeat (4) tick();
        check("post_rst_idle", {busy, halted, pc_out}, 0);
        check("post_rst_a", alu_a, 0);
        launch(1'b0);
        check("post_rst_start", {busy, pc_out}, {1'b1, 4'h0});

        // start held high through the run and after HLT
        do_reset();
        launch(1'b1);
        run_to_halt(cyc);
        check("hold_cycles", cyc, 12);
        repeat (10) tick();
        check("hold_halted", {halted, busy}, 2'b10);
        check("hold_pc", pc_out, 4);
        check("hold_ov_pulses", ov_cnt, 1);
        check("hold_out_data", out_data, 8'h08);
        start = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
